data_memory_ws: RTL and testbench

//  Next-generation unified text/data memory for the MIPS datapath: DEPTH 32-bit words, shared by
//  an asynchronous instruction port and a handshaked data port. Data port adds byte-lane writes,

---
 rtl/data_memory_ws.sv | 105 ++++++++++
 tb/tb_data_memory_ws.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ws.sv
// Unified text/data word memory with an async instruction port and a handshaked data port
// Ports: clk/reset; pc_address->instruction (comb); d_req/d_we/d_be/address/dataIn in,
//        dataOut/d_ready/d_err/d_busy out; data access takes 1+DATA_WAIT cycles, requests dropped while busy
module data_memory_ws #(
  parameter int DEPTH       = 4096,
  parameter int DATA_OFFSET = 2048,
  parameter int TEXT_WORDS  = 1024,
  parameter int DATA_WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_address,
  output logic [31:0] instruction,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] address,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        d_ready,
  output logic        d_err,
  output logic        d_busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [AW-1:0] r_idx;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdat;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic [31:0] w_pc_idx;
  logic [31:0] w_off;
  logic [31:0] w_idx;
  logic        w_err;

  // Instruction port: plain combinational read, out-of-range fetches return zero.
  assign w_pc_idx    = pc_address >> 2;
  assign instruction = (w_pc_idx < 32'(DEPTH)) ? r_mem[w_pc_idx[AW-1:0]] : 32'h0;

  // Data address decode; unsigned wrap below DATA_OFFSET is caught by the explicit compare.
  assign w_off = address - 32'(DATA_OFFSET);
  assign w_idx = w_off >> 2;
  assign w_err = (address < 32'(DATA_OFFSET)) ||
                 (w_idx >= 32'(DEPTH)) ||
                 (address[1:0] != 2'b00) ||
                 (d_we && (w_idx < 32'(TEXT_WORDS)));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (d_req) w_next = (DATA_WAIT == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == 4'd1) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_be    <= 4'd0;
      r_wdat  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && d_req) begin
        // Everything the access needs is frozen here; later input changes are ignored.
        r_idx  <= w_idx[AW-1:0];
        r_we   <= d_we;
        r_be   <= d_be;
        r_wdat <= dataIn;
        r_err  <= w_err;
        r_cnt  <= 4'(DATA_WAIT);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Write commits on the edge leaving RESP; a reset on that edge cancels it.
  always_ff @(posedge clk) begin
    if (!reset && r_state == S_RESP && r_we && !r_err) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[r_idx][8*i +: 8] <= r_wdat[8*i +: 8];
      end
    end
  end

  assign d_busy  = (r_state != S_IDLE);
  assign d_ready = (r_state == S_RESP);
  assign d_err   = (r_state == S_RESP) && r_err;
  assign dataOut = (r_state == S_RESP && !r_we && !r_err) ? r_mem[r_idx] : 32'h0;

endmodule

// File: tb/tb_data_memory_ws.sv
// Directed self-checking bench for data_memory_ws
// Two instances: DATA_WAIT=2 (main) and DATA_WAIT=0 (back-to-back)
// Data index = (address-0x800)>>2, so 0x1800 is the first non-text word (pc 0x1000)
module tb_data_memory_ws;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] pc_address, instruction;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] address, dataIn, dataOut;
  logic        d_ready, d_err, d_busy;

  logic        reset0;
  logic [31:0] pc_address0, instruction0;
  logic        d_req0, d_we0;
  logic [3:0]  d_be0;
  logic [31:0] address0, dataIn0, dataOut0;
  logic        d_ready0, d_err0, d_busy0;

  int checks = 0;
  int failures = 0;

  data_memory_ws #(.DATA_WAIT(2)) u_dut (
    .clk(clk), .reset(reset), .pc_address(pc_address), .instruction(instruction),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .address(address), .dataIn(dataIn),
    .dataOut(dataOut), .d_ready(d_ready), .d_err(d_err), .d_busy(d_busy)
  );

  data_memory_ws #(.DATA_WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset0), .pc_address(pc_address0), .instruction(instruction0),
    .d_req(d_req0), .d_we(d_we0), .d_be(d_be0), .address(address0), .dataIn(dataIn0),
    .dataOut(dataOut0), .d_ready(d_ready0), .d_err(d_err0), .d_busy(d_busy0)
  );

  // Stimulus helper: issue one access on the main DUT and wait (bounded) for d_ready.
  task automatic do_access(input logic we, input logic [3:0] be, input logic [31:0] a,
                           input logic [31:0] din, output logic [31:0] dout,
                           output logic err, output int lat, output logic [31:0] ins);
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_be = be; address = a; dataIn = din;
    @(negedge clk);
    d_req = 1'b0;
    lat = 1;
    while (!d_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    dout = dataOut; err = d_err; ins = instruction;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset0 = 1'b1;
    d_req = 0; d_we = 0; d_be = 0; address = 0; dataIn = 0; pc_address = 0;
    d_req0 = 0; d_we0 = 0; d_be0 = 0; address0 = 0; dataIn0 = 0; pc_address0 = 0;
    repeat (3) @(negedge clk);
    checks++; if ({d_ready, d_err, d_busy} !== 3'b000) begin failures++;
      $display("FAIL reset_flags got=%b exp=000", {d_ready, d_err, d_busy}); end
    checks++; if (dataOut !== 32'h0) begin failures++;
      $display("FAIL reset_dataOut got=%h exp=00000000", dataOut); end
    checks++; if ({d_ready0, d_err0, d_busy0, dataOut0} !== 35'h0) begin failures++;
      $display("FAIL reset_dut0 got=%h exp=0", {d_ready0, d_err0, d_busy0, dataOut0}); end
    reset = 1'b0; reset0 = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] dout, ins; logic err; int lat;
    pc_address = 32'h1000;
    do_access(1'b1, 4'hF, 32'h1800, 32'hDEADBEEF, dout, err, lat, ins);
    checks++; if (lat !== 3) begin failures++;
      $display("FAIL wr_latency got=%0d exp=3", lat); end
    checks++; if (err !== 1'b0 || dout !== 32'h0) begin failures++;
      $display("FAIL wr_resp got=%b/%h exp=0/00000000", err, dout); end
    @(negedge clk);
    checks++; if (instruction !== 32'hDEADBEEF) begin failures++;
      $display("FAIL ifetch_after_wr got=%h exp=deadbeef", instruction); end
    do_access(1'b0, 4'hF, 32'h1800, 32'h0, dout, err, lat, ins);
    checks++; if (lat !== 3 || err !== 1'b0 || dout !== 32'hDEADBEEF) begin failures++;
      $display("FAIL rd_basic got=%0d/%b/%h exp=3/0/deadbeef", lat, err, dout); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] dout, ins; logic err; int lat;
    pc_address = 32'h1008;
    do_access(1'b1, 4'hF, 32'h1808, 32'h11223344, dout, err, lat, ins);
    do_access(1'b1, 4'b0101, 32'h1808, 32'hAABBCCDD, dout, err, lat, ins);
    checks++; if (ins !== 32'h11223344) begin failures++;
      $display("FAIL ifetch_before_commit got=%h exp=11223344", ins); end
    @(negedge clk);
    checks++; if (instruction !== 32'h11BB33DD) begin failures++;
      $display("FAIL ifetch_after_commit got=%h exp=11bb33dd", instruction); end
    do_access(1'b0, 4'hF, 32'h1808, 32'h0, dout, err, lat, ins);
    checks++; if (dout !== 32'h11BB33DD || err !== 1'b0) begin failures++;
      $display("FAIL byte_lane_rd got=%h/%b exp=11bb33dd/0", dout, err); end
    do_access(1'b1, 4'b0000, 32'h1808, 32'hFFFFFFFF, dout, err, lat, ins);
    checks++; if (err !== 1'b0) begin failures++;
      $display("FAIL be0_err got=%b exp=0", err); end
    do_access(1'b0, 4'hF, 32'h1808, 32'h0, dout, err, lat, ins);
    checks++; if (dout !== 32'h11BB33DD) begin failures++;
      $display("FAIL be0_unchanged got=%h exp=11bb33dd", dout); end
  endtask

  task automatic test_errors();
    logic [31:0] dout, ins; logic err; int lat;
    do_access(1'b0, 4'hF, 32'h1802, 32'h0, dout, err, lat, ins);
    checks++; if (err !== 1'b1 || dout !== 32'h0) begin failures++;
      $display("FAIL misaligned got=%b/%h exp=1/00000000", err, dout); end
    do_access(1'b1, 4'hF, 32'h0800, 32'h01020304, dout, err, lat, ins);
    checks++; if (err !== 1'b1 || lat !== 3) begin failures++;
      $display("FAIL text_write got=%b/%0d exp=1/3", err, lat); end
    do_access(1'b1, 4'hF, 32'h17FC, 32'h01020304, dout, err, lat, ins);
    checks++; if (err !== 1'b1) begin failures++;
      $display("FAIL last_text_write got=%b exp=1", err); end
    do_access(1'b0, 4'hF, 32'h0800, 32'h0, dout, err, lat, ins);
    checks++; if (err !== 1'b0) begin failures++;
      $display("FAIL text_read got=%b exp=0", err); end
    do_access(1'b0, 4'hF, 32'h0004, 32'h0, dout, err, lat, ins);
    checks++; if (err !== 1'b1 || dout !== 32'h0) begin failures++;
      $display("FAIL below_offset got=%b/%h exp=1/00000000", err, dout); end
    do_access(1'b0, 4'hF, 32'h4800, 32'h0, dout, err, lat, ins);
    checks++; if (err !== 1'b1) begin failures++;
      $display("FAIL idx_range got=%b exp=1", err); end
    pc_address = 32'h4000;
    @(negedge clk);
    checks++; if (instruction !== 32'h0) begin failures++;
      $display("FAIL ifetch_range got=%h exp=00000000", instruction); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    d_req0 = 1'b1; d_we0 = 1'b0; d_be0 = 4'hF; address0 = 32'h1800;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (d_ready0 !== ((i % 2) == 0)) begin failures++;
        $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, d_ready0, (i % 2) == 0); end
    end
    // d_req is still high through this RESP cycle, then dropped.
    @(negedge clk);
    checks++; if (d_ready0 !== 1'b1 || d_err0 !== 1'b0) begin failures++;
      $display("FAIL b2b_last got=%b/%b exp=1/0", d_ready0, d_err0); end
    @(negedge clk);
    d_req0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (d_ready0 !== 1'b0 || d_busy0 !== 1'b0) begin failures++;
        $display("FAIL resp_pulse_dropped[%0d] got=%b/%b exp=0/0", i, d_ready0, d_busy0); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] dout, ins; logic err; int lat; int seen;
    do_access(1'b1, 4'hF, 32'h1804, 32'hCAFEF00D, dout, err, lat, ins);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; address = 32'h1804; dataIn = 32'h12345678;
    @(negedge clk);
    d_req = 1'b0;
    checks++; if (d_busy !== 1'b1) begin failures++;
      $display("FAIL busy_in_wait got=%b exp=1", d_busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (d_busy !== 1'b0 || d_ready !== 1'b0) begin failures++;
      $display("FAIL reset_abort got=%b/%b exp=0/0", d_busy, d_ready); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (d_ready) seen++;
    end
    checks++; if (seen !== 0) begin failures++;
      $display("FAIL ready_after_abort got=%0d exp=0", seen); end
    do_access(1'b0, 4'hF, 32'h1804, 32'h0, dout, err, lat, ins);
    checks++; if (dout !== 32'hCAFEF00D || err !== 1'b0) begin failures++;
      $display("FAIL no_commit_after_reset got=%h/%b exp=cafef00d/0", dout, err); end
  endtask

  task automatic test_capture();
    logic [31:0] dout, ins; logic err; int lat;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; address = 32'h180C; dataIn = 32'h55667788;
    @(negedge clk);
    address = 32'h1810; dataIn = 32'h0; d_we = 1'b0; d_be = 4'h0;   // d_req stays high in WAIT
    @(negedge clk);
    d_req = 1'b0;
    lat = 2;
    while (!d_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 3 || d_err !== 1'b0 || dataOut !== 32'h0) begin failures++;
      $display("FAIL capture_wr got=%0d/%b/%h exp=3/0/00000000", lat, d_err, dataOut); end
    @(negedge clk);
    checks++; if (d_ready !== 1'b0 || d_busy !== 1'b0) begin failures++;
      $display("FAIL wait_req_dropped got=%b/%b exp=0/0", d_ready, d_busy); end
    do_access(1'b0, 4'hF, 32'h180C, 32'h0, dout, err, lat, ins);
    checks++; if (dout !== 32'h55667788) begin failures++;
      $display("FAIL capture_data got=%h exp=55667788", dout); end
    // Read whose address turns misaligned during WAIT must still use the captured address.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; address = 32'h1800;
    @(negedge clk);
    d_req = 1'b0; address = 32'h1802;
    lat = 1;
    while (!d_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (dataOut !== 32'hDEADBEEF || d_err !== 1'b0) begin failures++;
      $display("FAIL capture_addr got=%h/%b exp=deadbeef/0", dataOut, d_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_errors();
    test_back_to_back();
    test_reset_mid_access();
    test_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
